// File: rtl/tx_ctrl_pkg.sv
// Shared definitions for the command-transmit control path: FSM encoding,
// command word layout and default inter-command gap values.
package tx_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } arb_state_e;

  // Command word layout: {dev, mod, addr, data}
  localparam int CMD_W    = 32;
  localparam int DEV_LSB  = 24;
  localparam int MOD_LSB  = 16;
  localparam int ADDR_LSB = 8;
  localparam int DATA_LSB = 0;

  // Hold-off long enough for the serial encoder to shift out one frame:
  // 4 bytes x 11 bits x 1000 clocks per bit. The sim value is 100x shorter.
  localparam logic [19:0] GAP_HW  = 20'd44000;
  localparam logic [19:0] GAP_SIM = 20'd440;

endpackage

// File: rtl/tx_cmd_rr4.sv
// Combinational 4-way round-robin selector: first set request bit found
// searching upward from ptr, wrapping modulo 4.
module tx_cmd_rr4 (
  input  logic [3:0] req,
  input  logic [1:0] ptr,
  output logic       any,
  output logic [1:0] win
);

  logic [1:0] idx;
  logic       found;

  // Scan ptr, ptr+1, ... with natural 2-bit wrap; first hit wins
  always_comb begin
    any   = |req;
    win   = ptr;
    idx   = ptr;
    found = 1'b0;
    for (int k = 0; k < 4; k++) begin
      idx = ptr + 2'(k);
      if (!found && req[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tx_cmd_arb.sv
// Round-robin arbiter feeding the single command-transmit interface.
// A granted command is strobed for one cycle, then the arbiter holds off
// for cmd_gap cycles (minimum 1) so the serial phy can finish the frame.
module tx_cmd_arb
  import tx_ctrl_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int CNT_W = 20
) (
  input  logic                  clk_sys,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req,
  input  logic [CMD_W*NREQ-1:0] req_cmd,
  output logic [NREQ-1:0]       req_ack,
  input  logic [CNT_W-1:0]      cmd_gap,
  output logic [7:0]            cmdt_dev,
  output logic [7:0]            cmdt_mod,
  output logic [7:0]            cmdt_addr,
  output logic [7:0]            cmdt_data,
  output logic                  cmdt_vld,
  output logic                  busy,
  output logic [15:0]           cmd_cnt
);

  arb_state_e         state_q;
  logic [1:0]         ptr_q;
  logic [1:0]         win_q;
  logic [CNT_W-1:0]   gap_q;
  logic [CMD_W-1:0]   word_q;
  logic               vld_q;
  logic [NREQ-1:0]    ack_q;
  logic               busy_q;
  logic [15:0]        cnt_q;

  logic               rr_any;
  logic [1:0]         rr_win;

  tx_cmd_rr4 u_rr (
    .req (req[3:0]),
    .ptr (ptr_q),
    .any (rr_any),
    .win (rr_win)
  );

  // Arbitration FSM; strobe, ack, busy and counter are registered with state
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      win_q   <= '0;
      gap_q   <= '0;
      word_q  <= '0;
      vld_q   <= 1'b0;
      ack_q   <= '0;
      busy_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      vld_q <= 1'b0;
      ack_q <= '0;
      case (state_q)
        IDLE: begin
          if (rr_any) begin
            word_q  <= req_cmd[{rr_win, 5'd0} +: CMD_W];
            win_q   <= rr_win;
            vld_q   <= 1'b1;
            ack_q   <= NREQ'(1) << rr_win;
            cnt_q   <= cnt_q + 16'd1;
            busy_q  <= 1'b1;
            state_q <= ISSUE;
          end
        end
        ISSUE: begin
          // Gap is sampled only here; zero is stretched to one cycle
          ptr_q   <= win_q + 2'd1;
          gap_q   <= (cmd_gap == '0) ? CNT_W'(1) : cmd_gap;
          state_q <= WAIT;
        end
        WAIT: begin
          if (gap_q == CNT_W'(1)) begin
            gap_q   <= '0;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            gap_q <= gap_q - CNT_W'(1);
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign cmdt_dev  = word_q[DEV_LSB  +: 8];
  assign cmdt_mod  = word_q[MOD_LSB  +: 8];
  assign cmdt_addr = word_q[ADDR_LSB +: 8];
  assign cmdt_data = word_q[DATA_LSB +: 8];
  assign cmdt_vld  = vld_q;
  assign req_ack   = ack_q;
  assign busy      = busy_q;
  assign cmd_cnt   = cnt_q;

endmodule
